// File: rtl/rv_pkg.sv
// Shared definitions for the five-stage RV32I integer pipeline: opcodes,
// ALU operation encoding, pipeline register layouts and decode helpers.
package rv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    alu_op_e     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        use_imm;
    logic        regwrite;
    logic        mem_read;
    logic        mem_write;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        regwrite;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        regwrite;
    logic [31:0] wdata;
  } mem_wb_t;

  // Immediate for the instruction's format; every non-S, non-U opcode uses I-type.
  function automatic logic [31:0] imm_decode(input logic [31:0] insn);
    case (insn[6:0])
      OPC_STORE: return {{20{insn[31]}}, insn[31:25], insn[11:7]};
      OPC_LUI:   return {insn[31:12], 12'b0};
      default:   return {{20{insn[31]}}, insn[31:20]};
    endcase
  endfunction

  // ALU operation from funct3; insn[30] picks SUB (register form only) and SRA.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic bit30,
                                          input logic is_op);
    case (f3)
      3'b000:  return (is_op && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU for the RV32I OP/OP-IMM subset.
module rv_alu
  import rv_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Select the result for the requested operation.
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'b0, a_i < b_i};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv_pipe_core.sv
// Five-stage in-order RV32I pipeline (ALU subset + LW/SW) with EX/MEM and
// MEM/WB forwarding, one-cycle load-use stall and cycle/retire counters.
module rv_pipe_core
  import rv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_insn,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic             dmem_wen,
  output logic             dmem_ren,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int         RIDX_W = $clog2(NREGS);
  // With 16 registers the top bit of every register field is dropped here.
  localparam logic [4:0] RMASK  = 5'(NREGS - 1);

  logic [XLEN-1:0]  pc_q;
  if_id_t           if_id_q;
  id_ex_t           id_ex_q, id_ex_d;
  ex_mem_t          ex_mem_q, ex_mem_d;
  mem_wb_t          mem_wb_q, mem_wb_d;
  logic [31:0]      rf_q [NREGS];
  logic             illegal_q;
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  // ---------------- ID: decode, register read, hazard detect ----------------
  logic [31:0] insn;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic        dec_legal, uses_rs1, uses_rs2, dec_use_imm, dec_regwrite;
  logic        dec_mread, dec_mwrite;
  alu_op_e     dec_op;
  logic [31:0] rs1_val, rs2_val;
  logic        load_use;

  assign insn  = if_id_q.insn;
  assign rs1_f = insn[19:15] & RMASK;
  assign rs2_f = insn[24:20] & RMASK;
  assign rd_f  = insn[11:7] & RMASK;

  // Decode control signals; unsupported opcodes leave dec_legal low.
  always_comb begin
    dec_legal    = 1'b0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    dec_use_imm  = 1'b0;
    dec_regwrite = 1'b0;
    dec_mread    = 1'b0;
    dec_mwrite   = 1'b0;
    dec_op       = ALU_ADD;
    case (insn[6:0])
      OPC_OP_IMM: begin
        dec_legal    = 1'b1;
        uses_rs1     = 1'b1;
        dec_use_imm  = 1'b1;
        dec_regwrite = 1'b1;
        dec_op       = alu_from_f3(insn[14:12], insn[30], 1'b0);
      end
      OPC_OP: begin
        dec_legal    = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
        dec_regwrite = 1'b1;
        dec_op       = alu_from_f3(insn[14:12], insn[30], 1'b1);
      end
      OPC_LUI: begin
        dec_legal    = 1'b1;
        dec_use_imm  = 1'b1;
        dec_regwrite = 1'b1;
      end
      OPC_LOAD: begin
        dec_legal    = 1'b1;
        uses_rs1     = 1'b1;
        dec_use_imm  = 1'b1;
        dec_regwrite = 1'b1;
        dec_mread    = 1'b1;
      end
      OPC_STORE: begin
        dec_legal    = 1'b1;
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
        dec_use_imm  = 1'b1;
        dec_mwrite   = 1'b1;
      end
      default: ;
    endcase
  end

  // Register read with write-first bypass of the WB-stage write; x0 reads 0.
  always_comb begin
    rs1_val = rf_q[rs1_f[RIDX_W-1:0]];
    rs2_val = rf_q[rs2_f[RIDX_W-1:0]];
    if (rs1_f == 5'd0)
      rs1_val = '0;
    else if (mem_wb_q.regwrite && mem_wb_q.rd == rs1_f)
      rs1_val = mem_wb_q.wdata;
    if (rs2_f == 5'd0)
      rs2_val = '0;
    else if (mem_wb_q.regwrite && mem_wb_q.rd == rs2_f)
      rs2_val = mem_wb_q.wdata;
  end

  // A load in EX cannot forward yet, so a dependent instruction in ID waits a cycle.
  always_comb begin
    load_use = 1'b0;
    if (if_id_q.valid && id_ex_q.mem_read && id_ex_q.rd != 5'd0)
      load_use = (uses_rs1 && id_ex_q.rd == rs1_f) || (uses_rs2 && id_ex_q.rd == rs2_f);
  end

  // Build the ID/EX entry; illegal opcodes and stall cycles become bubbles.
  always_comb begin
    id_ex_d = '0;
    if (if_id_q.valid && dec_legal && !load_use) begin
      id_ex_d.valid     = 1'b1;
      id_ex_d.alu_op    = dec_op;
      id_ex_d.rs1       = uses_rs1 ? rs1_f : 5'd0;
      id_ex_d.rs2       = uses_rs2 ? rs2_f : 5'd0;
      id_ex_d.rd        = dec_regwrite ? rd_f : 5'd0;
      id_ex_d.rs1_val   = uses_rs1 ? rs1_val : 32'd0;
      id_ex_d.rs2_val   = uses_rs2 ? rs2_val : 32'd0;
      id_ex_d.imm       = imm_decode(insn);
      id_ex_d.use_imm   = dec_use_imm;
      id_ex_d.regwrite  = dec_regwrite;
      id_ex_d.mem_read  = dec_mread;
      id_ex_d.mem_write = dec_mwrite;
    end
  end

  // ---------------- EX: forwarding and ALU ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_out;

  // Operand forwarding, youngest producer (EX/MEM) first.
  always_comb begin
    fwd_a = id_ex_q.rs1_val;
    fwd_b = id_ex_q.rs2_val;
    if (ex_mem_q.regwrite && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs1)
      fwd_a = ex_mem_q.alu_res;
    else if (mem_wb_q.regwrite && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs1)
      fwd_a = mem_wb_q.wdata;
    if (ex_mem_q.regwrite && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs2)
      fwd_b = ex_mem_q.alu_res;
    else if (mem_wb_q.regwrite && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs2)
      fwd_b = mem_wb_q.wdata;
  end

  assign alu_b = id_ex_q.use_imm ? id_ex_q.imm : fwd_b;

  rv_alu u_alu (
    .a_i      (fwd_a),
    .b_i      (alu_b),
    .op_i     (id_ex_q.alu_op),
    .result_o (alu_out)
  );

  // Carry the EX result and forwarded store data into MEM.
  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.valid      = id_ex_q.valid;
    ex_mem_d.rd         = id_ex_q.rd;
    ex_mem_d.regwrite   = id_ex_q.regwrite;
    ex_mem_d.mem_read   = id_ex_q.mem_read;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.alu_res    = alu_out;
    ex_mem_d.store_data = fwd_b;
  end

  // ---------------- MEM ----------------
  // Strobes are suppressed while reset is held so an in-flight SW never writes.
  assign dmem_addr  = ex_mem_q.alu_res;
  assign dmem_wdata = ex_mem_q.store_data;
  assign dmem_wen   = ex_mem_q.mem_write & ~rst;
  assign dmem_ren   = ex_mem_q.mem_read & ~rst;

  // Select load data or ALU result for write-back.
  always_comb begin
    mem_wb_d          = '0;
    mem_wb_d.valid    = ex_mem_q.valid;
    mem_wb_d.rd       = ex_mem_q.rd;
    mem_wb_d.regwrite = ex_mem_q.regwrite;
    mem_wb_d.wdata    = ex_mem_q.mem_read ? dmem_rdata : ex_mem_q.alu_res;
  end

  // ---------------- State ----------------
  // Advance PC and pipeline registers; a load-use stall freezes PC and IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      if (!load_use) begin
        pc_q          <= pc_q + XLEN'(4);
        if_id_q.valid <= 1'b1;
        if_id_q.insn  <= imem_insn;
      end
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Register file: cleared on reset, written from WB, x0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= '0;
    end else if (mem_wb_q.regwrite && mem_wb_q.rd != 5'd0) begin
      rf_q[mem_wb_q.rd[RIDX_W-1:0]] <= mem_wb_q.wdata;
    end
  end

  // Sticky flag for any unsupported opcode seen in ID.
  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (if_id_q.valid && !dec_legal)
      illegal_q <= 1'b1;
  end

  // Free-running cycle counter and retire counter (bubbles do not retire).
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (mem_wb_q.valid)
        instret_cnt_q <= instret_cnt_q + CNT_W'(1);
    end
  end

  assign imem_addr   = pc_q;
  assign illegal     = illegal_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_rv_pipe_core.sv
// Directed bench for rv_pipe_core: programs end in stores, and a scoreboard
// of expected (address, data, cycle) triples is checked on every dmem_wen.
module tb_rv_pipe_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_insn, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_wen, dmem_ren, illegal;
  logic [31:0] cycle_cnt, instret_cnt;

  logic [31:0] imem [128];
  logic [31:0] dmem [16];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } st_t;
  st_t exp_q[$];

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0]  OPI = 7'b0010011;
  localparam logic [6:0]  LDO = 7'b0000011;

  rv_pipe_core #(
    .XLEN(32), .NREGS(32), .RESET_PC(32'h0), .CNT_W(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_insn   (imem_insn),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wen    (dmem_wen),
    .dmem_ren    (dmem_ren),
    .dmem_rdata  (dmem_rdata),
    .illegal     (illegal),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  assign imem_insn  = imem[imem_addr[8:2]];
  assign dmem_rdata = dmem[dmem_addr[5:2]];

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic exp_st(input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] cyc);
    st_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Observe the current cycle at the falling edge, then step to the next cycle.
  task automatic cyc();
    st_t e;
    @(negedge clk);
    chk("wen_ren_excl", 32'(dmem_wen & dmem_ren), 32'd0);
    if (dmem_wen === 1'b1) begin
      chk("store_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("store addr=%h data=%h cycle=%0d", dmem_addr, dmem_wdata, cycle_cnt);
        chk("st_addr", dmem_addr, e.addr);
        chk("st_data", dmem_wdata, e.data);
        chk("st_cycle", cycle_cnt, e.cyc);
      end
      dmem[dmem_addr[5:2]] = dmem_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = NOP;
    for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
    dmem[13] = 32'hDEAD_BEEF;

    // Program 1; store at index k reaches MEM in cycle k+3, +1 after the load-use stall.
    imem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);            // ADDI x1,x0,5
    imem[1]  = enc_i(12'd3, 5'd1, 3'b000, 5'd2, OPI);            // ADDI x2,x1,3
    imem[2]  = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);            // ADD  x3,x1,x2
    imem[3]  = enc_s(12'd0, 5'd3, 5'd0);                         // SW   x3,0(x0)
    imem[4]  = enc_i(12'd0, 5'd0, 3'b010, 5'd4, LDO);            // LW   x4,0(x0)
    imem[5]  = enc_i(12'd1, 5'd4, 3'b000, 5'd5, OPI);            // ADDI x5,x4,1
    imem[6]  = enc_s(12'd4, 5'd5, 5'd0);                         // SW   x5,4(x0)
    imem[7]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd6, OPI);          // ADDI x6,x0,-1
    imem[8]  = enc_r(7'd0, 5'd6, 5'd0, 3'b011, 5'd7);            // SLTU x7,x0,x6
    imem[9]  = enc_r(7'd0, 5'd6, 5'd0, 3'b010, 5'd8);            // SLT  x8,x0,x6
    imem[10] = enc_i(12'h404, 5'd6, 3'b101, 5'd9, OPI);          // SRAI x9,x6,4
    imem[11] = enc_i(12'h004, 5'd6, 3'b101, 5'd10, OPI);         // SRLI x10,x6,4
    imem[12] = enc_s(12'd8, 5'd6, 5'd0);
    imem[13] = enc_s(12'd12, 5'd7, 5'd0);
    imem[14] = enc_s(12'd16, 5'd8, 5'd0);
    imem[15] = enc_s(12'd20, 5'd9, 5'd0);
    imem[16] = enc_s(12'd24, 5'd10, 5'd0);
    imem[17] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI);            // ADDI x0,x0,7
    imem[18] = enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd12);           // ADD  x12,x0,x0
    imem[19] = enc_u(20'h12345, 5'd11);                          // LUI  x11,0x12345
    imem[20] = enc_s(12'd28, 5'd12, 5'd0);
    imem[21] = enc_s(12'd32, 5'd11, 5'd0);
    imem[22] = 32'h0000_0063;                                    // BEQ: unsupported
    imem[23] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd13);     // SUB  x13,x1,x2
    imem[24] = enc_i(12'd0, 5'd6, 3'b010, 5'd14, OPI);           // SLTI x14,x6,0
    imem[25] = enc_s(12'd36, 5'd13, 5'd0);
    imem[26] = enc_s(12'd40, 5'd14, 5'd0);

    exp_st(32'd0,  32'd13,          32'd6);
    exp_st(32'd4,  32'd14,          32'd10);
    exp_st(32'd8,  32'hFFFF_FFFF,   32'd16);
    exp_st(32'd12, 32'd1,           32'd17);
    exp_st(32'd16, 32'd0,           32'd18);
    exp_st(32'd20, 32'hFFFF_FFFF,   32'd19);
    exp_st(32'd24, 32'h0FFF_FFFF,   32'd20);
    exp_st(32'd28, 32'd0,           32'd24);
    exp_st(32'd32, 32'h1234_5000,   32'd25);
    exp_st(32'd36, 32'hFFFF_FFFD,   32'd29);
    exp_st(32'd40, 32'd1,           32'd30);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cycle 0 after reset release.
    chk("rst_pc", imem_addr, 32'h0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_instret", instret_cnt, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_wen", 32'(dmem_wen), 32'd0);
    chk("rst_ren", 32'(dmem_ren), 32'd0);

    for (int c = 0; c <= 60; c++) begin
      if (c == 7) begin
        chk("instret_c7", instret_cnt, 32'd3);
        chk("cycle_c7", cycle_cnt, 32'd7);
        chk("lw_ren_c7", 32'(dmem_ren), 32'd1);
        chk("lw_addr_c7", dmem_addr, 32'd0);
      end
      if (c == 8) chk("lw_ren_c8", 32'(dmem_ren), 32'd0);
      if (c == 24) chk("illegal_c24", 32'(illegal), 32'd0);
      if (c == 25) chk("illegal_c25", 32'(illegal), 32'd1);
      if (c == 60) begin
        chk("instret_c60", instret_cnt, 32'd54);
        chk("illegal_c60", 32'(illegal), 32'd1);
      end
      cyc();
    end
    chk("sb_empty_1", exp_q.size(), 32'd0);

    // Program 2: reset while SW x2 is in EX (and SW x1 is in MEM).
    rst = 1'b1;
    for (int i = 0; i < 128; i++) imem[i] = NOP;
    imem[0] = enc_i(12'd9, 5'd0, 3'b000, 5'd1, OPI);             // ADDI x1,x0,9
    imem[1] = enc_i(12'd11, 5'd0, 3'b000, 5'd2, OPI);            // ADDI x2,x0,11
    imem[2] = enc_s(12'd44, 5'd1, 5'd0);                         // SW   x1,44(x0)
    imem[3] = enc_s(12'd48, 5'd2, 5'd0);                         // SW   x2,48(x0)
    cyc();
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) cyc();
    rst = 1'b1;
    #1;
    chk("midrst_wen", 32'(dmem_wen), 32'd0);
    chk("midrst_ren", 32'(dmem_ren), 32'd0);
    for (int i = 0; i < 128; i++) imem[i] = NOP;
    imem[0] = enc_s(12'd52, 5'd1, 5'd0);                         // SW x1,52(x0)
    cyc();
    rst = 1'b0;
    exp_st(32'd52, 32'd0, 32'd3);                                // x1 cleared by reset

    chk("midrst_pc", imem_addr, 32'h0);
    chk("midrst_cycle_cnt", cycle_cnt, 32'd0);
    chk("midrst_instret", instret_cnt, 32'd0);
    chk("midrst_illegal", 32'(illegal), 32'd0);

    for (int c = 0; c < 12; c++) cyc();
    chk("instret_p2_c12", instret_cnt, 32'd8);
    chk("sb_empty_2", exp_q.size(), 32'd0);
    chk("mem44_untouched", dmem[11], 32'd0);
    chk("mem48_untouched", dmem[12], 32'd0);
    chk("mem52_written", dmem[13], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
